mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Memory stage plus MEM/WB pipeline latch of the 5-stage MIPS pipeline.
- Sits directly downstream of the EX/MEM latch and consumes its outputs.
- Drives the data-cache request and holds it until dhit, producing mem_stall for the hazard unit.
- Selects writeback data and registers it, with the write controls, into MEM/WB for the register file.

Parameters:
DATA_W, 32, datapath/address width
REG_W, 5, register-index width

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
en  in  1  pipeline advance (MEM/WB latch enable, from hazard unit)
flush  in  1  insert bubble into MEM/WB on advance
dREN_in  in  1  load request from EX/MEM
dWEN_in  in  1  store request from EX/MEM
portO_in  in  DATA_W  ALU result / memory address
dmemstore_in  in  DATA_W  store data
regWr_in  in  1  register write enable
wsel_in  in  REG_W  destination register
memToReg_in  in  2  writeback select
luiValue_in  in  DATA_W  LUI result
pc4_in  in  DATA_W  PC+4 (JAL link)
halt_in  in  1  halt marker
dhit  in  1  cache completion
dmemload  in  DATA_W  cache load data
dmemREN  out  1  cache read request
dmemWEN  out  1  cache write request
dmemaddr  out  DATA_W  cache address (= portO_in)
dmemstore  out  DATA_W  cache write data (= dmemstore_in)
mem_stall  out  1  stage cannot advance
regWr_out  out  1  MEM/WB write enable
wsel_out  out  REG_W  MEM/WB destination
wdat_out  out  DATA_W  MEM/WB writeback data
halt_out  out  1  MEM/WB halt (sticky)

Behaviour:
- One clock (CLK); reset nRST is asynchronous and active-low. On reset: state=IDLE, load_buf=0, regWr_out=0, wsel_out=0, wdat_out=0, halt_out=0. Request outputs deassert combinationally while nRST=0.
- memop = (dREN_in|dWEN_in) & !halt_in. When dREN_in and dWEN_in are both 1 (illegal), the op is treated as a store: dmemWEN=1, dmemREN=0.
- FSM states: IDLE, WAIT, DONE.
  - IDLE, memop: drive the request this cycle. dhit=1 -> capture, then go DONE if en=0, else stay IDLE. dhit=0 -> WAIT.
  - WAIT: drive the request. dhit=1 -> capture, then go DONE if en=0, else IDLE.
  - DONE: request deasserted, op complete. en=1 -> IDLE.
- Capture: on dhit for a load, load_buf <= dmemload. Stores do not touch load_buf.
- Request outputs are asserted only when memop and state is IDLE or WAIT. dmemaddr and dmemstore are combinational pass-throughs.
- mem_stall = memop & (state!=DONE) & !dhit (combinational). A same-cycle dhit therefore does not stall.
- Load data ld = (state==DONE) ? load_buf : dmemload.
- Writeback select: memToReg 0 -> portO_in, 1 -> ld, 2 -> luiValue_in, 3 -> pc4_in.
- MEM/WB latch (posedge CLK, en=1):
  - flush=1: regWr_out=0, wsel_out=0, wdat_out=0; halt_out unchanged.
  - otherwise: latch regWr_in, wsel_in, the selected data, and halt_out |= halt_in.
  - en=0: hold all latch outputs.
- The hazard unit holds en=0 while mem_stall=1. If en=1 while mem_stall=1, the latch still updates (hazard-unit bug). The FSM is unaffected.
- halt_out is sticky until reset. With halt_in=1, no cache request is issued.
- dhit while no request is outstanding is ignored.
- Reset mid-WAIT aborts the access (request drops, state=IDLE). The op is not replayed by this block.

Test Plan:
- Reset: nRST=0 mid-WAIT with dREN_in=1 -> dmemREN=0 immediately; all outputs 0, state IDLE after release.
- Load with latency: dREN_in=1, portO_in=0x100, memToReg=1, wsel=5; dhit after 3 cycles with dmemload=0xDEADBEEF -> dmemREN high and mem_stall high for 3 cycles; on the dhit cycle mem_stall=0; with en=1 at that edge, wdat_out=0xDEADBEEF, wsel_out=5, regWr_out=1.
- Load completes but en held low 2 extra cycles, dmemload changes to 0 -> state DONE, dmemREN=0, mem_stall=0; on the en edge wdat_out=0xDEADBEEF.
- Store: dWEN_in=1, dmemstore_in=0x1234, dhit same cycle -> dmemWEN=1 one cycle, mem_stall=0, load_buf unchanged, regWr_out latches regWr_in=0.
- Select/flush: memToReg=2 with luiValue=0xABCD0000 -> wdat_out=0xABCD0000; memToReg=3 with pc4=0x44 -> 0x44. flush=1 with en=1 -> regWr_out=0, wdat_out=0.
- Halt: halt_in=1 with dREN_in=1 -> no dmemREN; halt_out=1 after en and stays 1 through later flush and halt_in=0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory stage and MEM/WB pipeline latch: issues the data-cache request, holds it
// until dhit, and registers the selected writeback data for the register file.
module mem_wb_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_W  = 5
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              en,
   input  logic              flush,
   input  logic              dREN_in,
   input  logic              dWEN_in,
   input  logic [DATA_W-1:0] portO_in,
   input  logic [DATA_W-1:0] dmemstore_in,
   input  logic              regWr_in,
   input  logic [REG_W-1:0]  wsel_in,
   input  logic [1:0]        memToReg_in,
   input  logic [DATA_W-1:0] luiValue_in,
   input  logic [DATA_W-1:0] pc4_in,
   input  logic              halt_in,
   input  logic              dhit,
   input  logic [DATA_W-1:0] dmemload,
   output logic              dmemREN,
   output logic              dmemWEN,
   output logic [DATA_W-1:0] dmemaddr,
   output logic [DATA_W-1:0] dmemstore,
   output logic              mem_stall,
   output logic              regWr_out,
   output logic [REG_W-1:0]  wsel_out,
   output logic [DATA_W-1:0] wdat_out,
   output logic              halt_out
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] load_buf_q, load_buf_d;
   logic              regWr_d, halt_d;
   logic [REG_W-1:0]  wsel_d;
   logic [DATA_W-1:0] wdat_d;
   logic              memop;
   logic              req_live;
   logic [DATA_W-1:0] ld;
   logic [DATA_W-1:0] wb_sel;

   // A halted instruction never touches memory; a simultaneous read+write is a store.
   assign memop     = (dREN_in | dWEN_in) & ~halt_in;
   assign req_live  = memop & (state_q != DONE) & nRST;
   assign dmemWEN   = req_live & dWEN_in;
   assign dmemREN   = req_live & dREN_in & ~dWEN_in;
   assign dmemaddr  = portO_in;
   assign dmemstore = dmemstore_in;
   assign mem_stall = memop & (state_q != DONE) & ~dhit;

   // Once the access has completed but the pipeline is frozen, use the buffered load.
   assign ld = (state_q == DONE) ? load_buf_q : dmemload;

   always_comb begin
      wb_sel = portO_in;
      case (memToReg_in)
         2'd0: wb_sel = portO_in;
         2'd1: wb_sel = ld;
         2'd2: wb_sel = luiValue_in;
         2'd3: wb_sel = pc4_in;
         default: wb_sel = portO_in;
      endcase
   end

   // Access sequencing; en only matters at completion, so a stall-time advance leaves it alone.
   always_comb begin
      state_d    = state_q;
      load_buf_d = load_buf_q;
      case (state_q)
         IDLE, WAIT: begin
            if (memop) begin
               if (dhit) begin
                  if (!dWEN_in) load_buf_d = dmemload;
                  state_d = en ? IDLE : DONE;
               end else begin
                  state_d = WAIT;
               end
            end else begin
               state_d = IDLE;
            end
         end
         DONE: begin
            if (en) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      regWr_d = regWr_out;
      wsel_d  = wsel_out;
      wdat_d  = wdat_out;
      halt_d  = halt_out;
      if (en) begin
         if (flush) begin
            regWr_d = 1'b0;
            wsel_d  = '0;
            wdat_d  = '0;
         end else begin
            regWr_d = regWr_in;
            wsel_d  = wsel_in;
            wdat_d  = wb_sel;
            halt_d  = halt_out | halt_in;
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q    <= IDLE;
         load_buf_q <= '0;
         regWr_out  <= 1'b0;
         wsel_out   <= '0;
         wdat_out   <= '0;
         halt_out   <= 1'b0;
      end else begin
         state_q    <= state_d;
         load_buf_q <= load_buf_d;
         regWr_out  <= regWr_d;
         wsel_out   <= wsel_d;
         wdat_out   <= wdat_d;
         halt_out   <= halt_d;
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus randomized
// transactions scored against a transaction-level model of the stage.
module tb_mem_wb_stage;

   localparam int unsigned DW = 32;
   localparam int unsigned RW = 5;

   logic          CLK, nRST, en, flush, dREN_in, dWEN_in, regWr_in, halt_in, dhit;
   logic [DW-1:0] portO_in, dmemstore_in, luiValue_in, pc4_in, dmemload;
   logic [RW-1:0] wsel_in;
   logic [1:0]    memToReg_in;
   logic          dmemREN, dmemWEN, mem_stall, regWr_out, halt_out;
   logic [DW-1:0] dmemaddr, dmemstore, wdat_out;
   logic [RW-1:0] wsel_out;

   int checks = 0;
   int errors = 0;

   // Model of architecturally visible state
   logic          exp_regWr;
   logic [RW-1:0] exp_wsel;
   logic [DW-1:0] exp_wdat;
   logic [DW-1:0] mdl_load_buf;

   mem_wb_stage #(.DATA_W(DW), .REG_W(RW)) dut (
      .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
      .dREN_in(dREN_in), .dWEN_in(dWEN_in), .portO_in(portO_in),
      .dmemstore_in(dmemstore_in), .regWr_in(regWr_in), .wsel_in(wsel_in),
      .memToReg_in(memToReg_in), .luiValue_in(luiValue_in), .pc4_in(pc4_in),
      .halt_in(halt_in), .dhit(dhit), .dmemload(dmemload),
      .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
      .dmemstore(dmemstore), .mem_stall(mem_stall), .regWr_out(regWr_out),
      .wsel_out(wsel_out), .wdat_out(wdat_out), .halt_out(halt_out)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      en = 1'b0; flush = 1'b0; dREN_in = 1'b0; dWEN_in = 1'b0; halt_in = 1'b0;
      dhit = 1'b0; regWr_in = 1'b0; wsel_in = '0; memToReg_in = 2'd0;
      portO_in = '0; dmemstore_in = '0; luiValue_in = '0; pc4_in = '0; dmemload = '0;
   endtask

   function automatic logic [DW-1:0] wb_value(input logic [1:0] m, input logic [DW-1:0] alu,
                                              input logic [DW-1:0] ldv, input logic [DW-1:0] lui,
                                              input logic [DW-1:0] pc4);
      if (m == 2'd0) return alu;
      if (m == 2'd1) return ldv;
      if (m == 2'd2) return lui;
      return pc4;
   endfunction

   task automatic test_reset();
      idle_inputs();
      nRST = 1'b0;
      repeat (2) step();
      nRST = 1'b1;
      step();
      dREN_in = 1'b1; portO_in = 32'h40;
      step(); step();
      #1;
      checks++;
      if (dmemREN !== 1'b1) begin errors++; $display("FAIL rst_wait_req got=%b exp=1", dmemREN); end
      nRST = 1'b0;
      #1;
      checks++;
      if (dmemREN !== 1'b0 || dmemWEN !== 1'b0) begin
         errors++; $display("FAIL rst_req_drop got ren=%b wen=%b exp=0/0", dmemREN, dmemWEN);
      end
      checks++;
      if (regWr_out !== 1'b0 || wsel_out !== '0 || wdat_out !== '0 || halt_out !== 1'b0) begin
         errors++;
         $display("FAIL rst_latch got regWr=%b wsel=%0d wdat=%h halt=%b exp=all 0",
                  regWr_out, wsel_out, wdat_out, halt_out);
      end
      dREN_in = 1'b0;
      step();
      nRST = 1'b1;
      step();
      // Fresh IDLE issues a request immediately; no clock edge is taken here.
      dREN_in = 1'b1;
      #1;
      checks++;
      if (dmemREN !== 1'b1 || mem_stall !== 1'b1) begin
         errors++; $display("FAIL rst_idle got ren=%b stall=%b exp=1/1", dmemREN, mem_stall);
      end
      dREN_in = 1'b0;
      step();
      exp_regWr = 1'b0; exp_wsel = '0; exp_wdat = '0; mdl_load_buf = '0;
   endtask

   task automatic test_load_latency();
      idle_inputs();
      dREN_in = 1'b1; portO_in = 32'h100; memToReg_in = 2'd1; wsel_in = 5'd5; regWr_in = 1'b1;
      dmemload = 32'h1111_2222;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (dmemREN !== 1'b1 || mem_stall !== 1'b1 || regWr_out !== 1'b0) begin
            errors++;
            $display("FAIL ld_stall c%0d got ren=%b stall=%b regWr=%b exp=1/1/0",
                     i, dmemREN, mem_stall, regWr_out);
         end
         step();
      end
      dhit = 1'b1; dmemload = 32'hDEAD_BEEF; en = 1'b1;
      #1;
      checks++;
      if (mem_stall !== 1'b0 || dmemREN !== 1'b1) begin
         errors++; $display("FAIL ld_hit got stall=%b ren=%b exp=0/1", mem_stall, dmemREN);
      end
      step();
      checks++;
      if (wdat_out !== 32'hDEAD_BEEF || wsel_out !== 5'd5 || regWr_out !== 1'b1) begin
         errors++;
         $display("FAIL ld_wb got wdat=%h wsel=%0d regWr=%b exp=deadbeef/5/1",
                  wdat_out, wsel_out, regWr_out);
      end
      mdl_load_buf = 32'hDEAD_BEEF;
      exp_regWr = 1'b1; exp_wsel = 5'd5; exp_wdat = 32'hDEAD_BEEF;
      idle_inputs();
   endtask

   task automatic test_select_flush();
      idle_inputs();
      en = 1'b1; regWr_in = 1'b1; wsel_in = 5'd9; memToReg_in = 2'd2; luiValue_in = 32'hABCD_0000;
      step();
      checks++;
      if (wdat_out !== 32'hABCD_0000 || wsel_out !== 5'd9) begin
         errors++; $display("FAIL sel_lui got wdat=%h wsel=%0d exp=abcd0000/9", wdat_out, wsel_out);
      end
      memToReg_in = 2'd3; pc4_in = 32'h44;
      step();
      checks++;
      if (wdat_out !== 32'h44) begin errors++; $display("FAIL sel_pc4 got=%h exp=44", wdat_out); end
      flush = 1'b1;
      step();
      checks++;
      if (regWr_out !== 1'b0 || wdat_out !== '0 || wsel_out !== '0) begin
         errors++;
         $display("FAIL flush got regWr=%b wsel=%0d wdat=%h exp=0/0/0", regWr_out, wsel_out, wdat_out);
      end
      flush = 1'b0; en = 1'b0; memToReg_in = 2'd2; luiValue_in = 32'h5555_0000;
      step();
      checks++;
      if (wdat_out !== '0 || regWr_out !== 1'b0) begin
         errors++; $display("FAIL en_hold got wdat=%h regWr=%b exp=0/0", wdat_out, regWr_out);
      end
      exp_regWr = 1'b0; exp_wsel = '0; exp_wdat = '0;
      idle_inputs();
   endtask

   task automatic test_load_hold();
      idle_inputs();
      dREN_in = 1'b1; portO_in = 32'h200; memToReg_in = 2'd1; wsel_in = 5'd7; regWr_in = 1'b1;
      dhit = 1'b1; dmemload = 32'hDEAD_BEEF;
      #1;
      checks++;
      if (mem_stall !== 1'b0) begin errors++; $display("FAIL hold_hit stall got=%b exp=0", mem_stall); end
      step();
      for (int i = 0; i < 2; i++) begin
         dhit = 1'b0; dmemload = '0;
         #1;
         checks++;
         if (dmemREN !== 1'b0 || mem_stall !== 1'b0 || wdat_out !== exp_wdat) begin
            errors++;
            $display("FAIL hold_done c%0d got ren=%b stall=%b wdat=%h exp=0/0/%h",
                     i, dmemREN, mem_stall, wdat_out, exp_wdat);
         end
         step();
      end
      en = 1'b1;
      step();
      checks++;
      if (wdat_out !== 32'hDEAD_BEEF || wsel_out !== 5'd7) begin
         errors++; $display("FAIL hold_wb got wdat=%h wsel=%0d exp=deadbeef/7", wdat_out, wsel_out);
      end
      mdl_load_buf = 32'hDEAD_BEEF;
      exp_regWr = 1'b1; exp_wsel = 5'd7; exp_wdat = 32'hDEAD_BEEF;
      idle_inputs();
   endtask

   task automatic test_store();
      idle_inputs();
      dWEN_in = 1'b1; dmemstore_in = 32'h1234; portO_in = 32'h300; wsel_in = 5'd3;
      dhit = 1'b1; en = 1'b1; dmemload = 32'h7777_7777;
      #1;
      checks++;
      if (dmemWEN !== 1'b1 || dmemREN !== 1'b0 || mem_stall !== 1'b0 ||
          dmemstore !== 32'h1234 || dmemaddr !== 32'h300) begin
         errors++;
         $display("FAIL st_req got wen=%b ren=%b stall=%b data=%h addr=%h exp=1/0/0/1234/300",
                  dmemWEN, dmemREN, mem_stall, dmemstore, dmemaddr);
      end
      step();
      checks++;
      if (regWr_out !== 1'b0 || wdat_out !== 32'h300) begin
         errors++; $display("FAIL st_wb got regWr=%b wdat=%h exp=0/300", regWr_out, wdat_out);
      end
      dWEN_in = 1'b0; dhit = 1'b0; en = 1'b0;
      #1;
      checks++;
      if (dmemWEN !== 1'b0) begin errors++; $display("FAIL st_one_cycle got wen=%b exp=0", dmemWEN); end
      // Read+write together acts as a store; buffered load data must survive it.
      dREN_in = 1'b1; dWEN_in = 1'b1; memToReg_in = 2'd1; regWr_in = 1'b1; wsel_in = 5'd4;
      dhit = 1'b1; dmemload = 32'h0BAD_0BAD;
      #1;
      checks++;
      if (dmemWEN !== 1'b1 || dmemREN !== 1'b0) begin
         errors++; $display("FAIL st_both got wen=%b ren=%b exp=1/0", dmemWEN, dmemREN);
      end
      step();
      dhit = 1'b0; en = 1'b1; dmemload = 32'h1357_9BDF;
      step();
      checks++;
      if (wdat_out !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL st_loadbuf got=%h exp=deadbeef", wdat_out);
      end
      exp_regWr = 1'b1; exp_wsel = 5'd4; exp_wdat = 32'hDEAD_BEEF;
      idle_inputs();
   endtask

   task automatic test_random();
      int kind, lat, hold;
      logic fl, exp_ren, exp_wen;
      logic [DW-1:0] ld_seen, ld_val;
      for (int t = 0; t < 60; t++) begin
         kind = int'($urandom_range(0, 3));
         lat  = int'($urandom_range(0, 3));
         hold = int'($urandom_range(0, 2));
         fl   = ($urandom_range(0, 4) == 0);
         dREN_in = (kind == 1 || kind == 3); dWEN_in = (kind >= 2); halt_in = 1'b0;
         exp_wen = dWEN_in; exp_ren = dREN_in & ~dWEN_in;
         portO_in = $urandom; dmemstore_in = $urandom; luiValue_in = $urandom; pc4_in = $urandom;
         regWr_in = 1'($urandom); wsel_in = RW'($urandom); memToReg_in = 2'($urandom);
         dmemload = $urandom; en = 1'b0; flush = 1'b0; dhit = 1'b0;
         if (kind != 0) begin
            for (int k = 0; k < lat; k++) begin
               #1;
               checks++;
               if (mem_stall !== 1'b1 || dmemREN !== exp_ren || dmemWEN !== exp_wen ||
                   wdat_out !== exp_wdat) begin
                  errors++;
                  $display("FAIL rnd_wait t%0d got stall=%b ren=%b wen=%b wdat=%h exp=1/%b/%b/%h",
                           t, mem_stall, dmemREN, dmemWEN, wdat_out, exp_ren, exp_wen, exp_wdat);
               end
               step();
            end
            ld_val = $urandom;
            dhit = 1'b1; dmemload = ld_val; en = (hold == 0); flush = (hold == 0) ? fl : 1'b0;
            ld_seen = ld_val;
            #1;
            checks++;
            if (mem_stall !== 1'b0 || dmemREN !== exp_ren || dmemWEN !== exp_wen ||
                dmemaddr !== portO_in) begin
               errors++;
               $display("FAIL rnd_hit t%0d got stall=%b ren=%b wen=%b exp=0/%b/%b",
                        t, mem_stall, dmemREN, dmemWEN, exp_ren, exp_wen);
            end
            if (kind == 1) mdl_load_buf = ld_val;
            step();
            for (int h = 0; h < hold; h++) begin
               dhit = 1'b0; dmemload = $urandom; en = (h == hold - 1); flush = en ? fl : 1'b0;
               ld_seen = mdl_load_buf;
               #1;
               checks++;
               if (mem_stall !== 1'b0 || dmemREN !== 1'b0 || dmemWEN !== 1'b0 ||
                   wdat_out !== exp_wdat) begin
                  errors++;
                  $display("FAIL rnd_done t%0d got stall=%b ren=%b wen=%b wdat=%h exp=0/0/0/%h",
                           t, mem_stall, dmemREN, dmemWEN, wdat_out, exp_wdat);
               end
               step();
            end
         end else begin
            // Stray dhit with no request must not disturb buffered load data.
            dhit = 1'($urandom); en = 1'b1; flush = fl; ld_seen = dmemload;
            #1;
            checks++;
            if (mem_stall !== 1'b0 || dmemREN !== 1'b0 || dmemWEN !== 1'b0) begin
               errors++;
               $display("FAIL rnd_noop t%0d got stall=%b ren=%b wen=%b exp=0/0/0",
                        t, mem_stall, dmemREN, dmemWEN);
            end
            step();
         end
         if (fl) begin
            exp_regWr = 1'b0; exp_wsel = '0; exp_wdat = '0;
         end else begin
            exp_regWr = regWr_in; exp_wsel = wsel_in;
            exp_wdat  = wb_value(memToReg_in, portO_in, ld_seen, luiValue_in, pc4_in);
         end
         checks++;
         if (regWr_out !== exp_regWr || wsel_out !== exp_wsel || wdat_out !== exp_wdat) begin
            errors++;
            $display("FAIL rnd_wb t%0d kind=%0d m2r=%0d got regWr=%b wsel=%0d wdat=%h exp=%b/%0d/%h",
                     t, kind, memToReg_in, regWr_out, wsel_out, wdat_out,
                     exp_regWr, exp_wsel, exp_wdat);
         end
      end
      idle_inputs();
   endtask

   task automatic test_halt();
      idle_inputs();
      #1;
      checks++;
      if (halt_out !== 1'b0) begin errors++; $display("FAIL halt_pre got=%b exp=0", halt_out); end
      halt_in = 1'b1; dREN_in = 1'b1; regWr_in = 1'b1;
      #1;
      checks++;
      if (dmemREN !== 1'b0 || mem_stall !== 1'b0) begin
         errors++; $display("FAIL halt_noreq got ren=%b stall=%b exp=0/0", dmemREN, mem_stall);
      end
      en = 1'b1;
      step();
      checks++;
      if (halt_out !== 1'b1) begin errors++; $display("FAIL halt_set got=%b exp=1", halt_out); end
      halt_in = 1'b0; dREN_in = 1'b0; flush = 1'b1;
      step();
      checks++;
      if (halt_out !== 1'b1 || regWr_out !== 1'b0) begin
         errors++; $display("FAIL halt_flush got halt=%b regWr=%b exp=1/0", halt_out, regWr_out);
      end
      flush = 1'b0;
      step();
      checks++;
      if (halt_out !== 1'b1) begin errors++; $display("FAIL halt_sticky got=%b exp=1", halt_out); end
      idle_inputs();
   endtask

   initial begin
      nRST = 1'b0;
      idle_inputs();
      test_reset();
      test_load_latency();
      test_select_flush();
      test_load_hold();
      test_store();
      test_random();
      test_halt();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
